// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave backed by a word-addressed memory array.
// The write and read channels run as independent FSMs that share the array; out-of-range accesses return SLVERR.
module axi4_lite_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 256
) (
    input  logic                  axi4_lite_clk,
    input  logic                  axi4_lite_rstn,
    input  logic [ADDR_WIDTH-1:0] S_AW_ADDR_IN,
    input  logic                  S_AW_VALID_IN,
    output logic                  S_AW_READY_OUT,
    input  logic [DATA_WIDTH-1:0] S_W_DATA_IN,
    input  logic [STRB_WIDTH-1:0] S_W_STRB_IN,
    input  logic                  S_W_VALID_IN,
    output logic                  S_W_READY_OUT,
    output logic [1:0]            S_B_RESP_OUT,
    output logic                  S_B_VALID_OUT,
    input  logic                  S_B_READY_IN,
    input  logic [ADDR_WIDTH-1:0] S_AR_ADDR_IN,
    input  logic                  S_AR_VALID_IN,
    output logic                  S_AR_READY_OUT,
    output logic [DATA_WIDTH-1:0] S_R_DATA_OUT,
    output logic [1:0]            S_R_RESP_OUT,
    output logic                  S_R_VALID_OUT,
    input  logic                  S_R_READY_IN
);

    localparam int                  IDX_W       = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT  = (ADDR_WIDTH + 1)'(DEPTH * 4);
    localparam logic [1:0]          RESP_OKAY   = 2'b00;
    localparam logic [1:0]          RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Not reset: contents survive axi4_lite_rstn.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t              w_state_reg;
    logic                  aw_done_reg;
    logic                  w_done_reg;
    logic [IDX_W-1:0]      aw_idx_reg;
    logic                  aw_ok_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;
    logic [STRB_WIDTH-1:0] w_strb_reg;
    logic                  aw_ready_reg;
    logic                  w_ready_reg;
    logic                  b_valid_reg;
    logic [1:0]            b_resp_reg;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  commit;
    logic [IDX_W-1:0]      wr_idx_next;
    logic                  wr_ok_next;
    logic [DATA_WIDTH-1:0] wr_data_next;
    logic [STRB_WIDTH-1:0] wr_strb_next;

    r_state_t              r_state_reg;
    logic                  ar_ready_reg;
    logic                  r_valid_reg;
    logic [DATA_WIDTH-1:0] r_data_reg;
    logic [1:0]            r_resp_reg;
    logic                  ar_ok;
    logic [IDX_W-1:0]      ar_idx;

    // A channel captured this cycle takes priority over its held copy.
    always_comb begin
        aw_hs        = S_AW_VALID_IN && aw_ready_reg;
        w_hs         = S_W_VALID_IN && w_ready_reg;
        wr_idx_next  = aw_hs ? S_AW_ADDR_IN[IDX_W+1:2] : aw_idx_reg;
        wr_ok_next   = aw_hs ? ({1'b0, S_AW_ADDR_IN} < ADDR_LIMIT) : aw_ok_reg;
        wr_data_next = w_hs ? S_W_DATA_IN : w_data_reg;
        wr_strb_next = w_hs ? S_W_STRB_IN : w_strb_reg;
        commit       = (w_state_reg == W_IDLE) && (aw_done_reg || aw_hs) && (w_done_reg || w_hs);
    end

    always_ff @(posedge axi4_lite_clk) begin
        if (commit && wr_ok_next) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (wr_strb_next[i]) begin
                    mem[wr_idx_next][i*8 +: 8] <= wr_data_next[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge axi4_lite_clk or negedge axi4_lite_rstn) begin
        if (!axi4_lite_rstn) begin
            w_state_reg  <= W_IDLE;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            aw_idx_reg   <= '0;
            aw_ok_reg    <= 1'b0;
            w_data_reg   <= '0;
            w_strb_reg   <= '0;
            aw_ready_reg <= 1'b0;
            w_ready_reg  <= 1'b0;
            b_valid_reg  <= 1'b0;
            b_resp_reg   <= RESP_OKAY;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    aw_idx_reg <= wr_idx_next;
                    aw_ok_reg  <= wr_ok_next;
                    w_data_reg <= wr_data_next;
                    w_strb_reg <= wr_strb_next;
                    if (commit) begin
                        w_state_reg  <= W_RESP;
                        aw_done_reg  <= 1'b0;
                        w_done_reg   <= 1'b0;
                        aw_ready_reg <= 1'b0;
                        w_ready_reg  <= 1'b0;
                        b_valid_reg  <= 1'b1;
                        b_resp_reg   <= wr_ok_next ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        aw_done_reg  <= aw_done_reg || aw_hs;
                        w_done_reg   <= w_done_reg || w_hs;
                        aw_ready_reg <= !(aw_done_reg || aw_hs);
                        w_ready_reg  <= !(w_done_reg || w_hs);
                    end
                end
                W_RESP: begin
                    if (S_B_READY_IN) begin
                        w_state_reg  <= W_IDLE;
                        b_valid_reg  <= 1'b0;
                        aw_ready_reg <= 1'b1;
                        w_ready_reg  <= 1'b1;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    assign ar_ok  = {1'b0, S_AR_ADDR_IN} < ADDR_LIMIT;
    assign ar_idx = S_AR_ADDR_IN[IDX_W+1:2];

    // Array read uses the pre-edge contents, so a same-edge write is not visible here.
    always_ff @(posedge axi4_lite_clk or negedge axi4_lite_rstn) begin
        if (!axi4_lite_rstn) begin
            r_state_reg  <= R_IDLE;
            ar_ready_reg <= 1'b0;
            r_valid_reg  <= 1'b0;
            r_data_reg   <= '0;
            r_resp_reg   <= RESP_OKAY;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_ready_reg && S_AR_VALID_IN) begin
                        r_state_reg  <= R_DATA;
                        ar_ready_reg <= 1'b0;
                        r_valid_reg  <= 1'b1;
                        r_data_reg   <= ar_ok ? mem[ar_idx] : '0;
                        r_resp_reg   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        ar_ready_reg <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_R_READY_IN) begin
                        r_state_reg  <= R_IDLE;
                        r_valid_reg  <= 1'b0;
                        ar_ready_reg <= 1'b1;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    assign S_AW_READY_OUT = aw_ready_reg;
    assign S_W_READY_OUT  = w_ready_reg;
    assign S_B_VALID_OUT  = b_valid_reg;
    assign S_B_RESP_OUT   = b_resp_reg;
    assign S_AR_READY_OUT = ar_ready_reg;
    assign S_R_VALID_OUT  = r_valid_reg;
    assign S_R_DATA_OUT   = r_data_reg;
    assign S_R_RESP_OUT   = r_resp_reg;

endmodule
